tap_data_path: RTL and testbench
================================

Name: tap_data_path

Overview:
Downstream consumer of the TAP controller. Takes the controller's 4-bit TAP state and the serial TDI line, and implements the JTAG instruction register, the BYPASS, IDCODE and boundary-scan data registers, and the TDO output mux. Drives the boundary-scan pin outputs during EXTEST.

Parameters:
IR_WIDTH, 4, instruction register length in bits (minimum 2)
BSR_LEN, 8, boundary-scan register length in cells
IDCODE_VALUE, 32'h1234_5001, device ID captured in CAPTURE_DR under IDCODE; bit 0 is 1
USERCODE_VALUE, 32'h0000_00A5, user code (used only with JTAG_USERCODE_EN)

Ports:
TCK  input  1  test clock; all state updates on rising edge
TRST  input  1  asynchronous, active-high reset
tap_state  input  4  TAP controller state code
TDI  input  1  serial test data in
TDO  output  1  serial test data out
TDO_EN  output  1  high when TDO is valid
ir_out  output  IR_WIDTH  currently active (updated) instruction
core_out  input  BSR_LEN  functional pin values from core logic
pins_in  input  BSR_LEN  values sampled from device pins
pins_out  output  BSR_LEN  values driven to device pins

Behaviour:
- State codes:
  - TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D
- Opcodes:
  - EXTEST = all zeros; IDCODE = 1; SAMPLE = 2; BYPASS = all ones.
  - Any undefined opcode selects BYPASS.
- TRST high (async):
  - ir_upd = IDCODE, ir_shift = 0, bypass = 0.
  - id_shift = IDCODE_VALUE, bsr_shift = 0, bsr_upd = 0.
  - TDO = 0, TDO_EN = 0, pins_out = core_out.
- TLR state: ir_upd <= IDCODE on each rising TCK (synchronous reset path).
- CAP_IR: ir_shift <= {0..0, 2'b01}.
- SH_IR: ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]}.
- UPD_IR: ir_upd <= ir_shift. ir_out = ir_upd at all times.
- CAP_DR, by selected register:
  - BYPASS: bypass <= 0.
  - IDCODE: id_shift <= IDCODE_VALUE.
  - SAMPLE or EXTEST: bsr_shift <= pins_in.
- SH_DR: the selected register shifts right with TDI into its MSB. Unselected registers hold.
- UPD_DR: if SAMPLE or EXTEST, bsr_upd <= bsr_shift. Other instructions update nothing.
- TDO is combinational:
  - SH_IR: ir_shift[0].
  - SH_DR: LSB of the selected data register.
  - Otherwise: 0.
- TDO_EN = (tap_state == SH_IR) || (tap_state == SH_DR).
- pins_out = (ir_upd == EXTEST) ? bsr_upd : core_out. This is combinational, so ir_out changes take effect in the cycle after UPD_IR.
- PAUSE and EXIT states: all registers hold.
- ir_out changes only on UPD_IR, TLR or TRST. An interrupted IR shift (EX1_IR to PAU_IR and back) resumes without loss.
- Unknown tap_state codes cannot occur (all 16 are defined).
- TRST asserted mid-shift discards all partial shift contents immediately.

Optional Feature:
- JTAG_USERCODE_EN defined:
  - Opcode 3 = USERCODE, selecting a 32-bit uc_shift register.
  - CAP_DR loads USERCODE_VALUE; TRST also loads USERCODE_VALUE.
  - It shifts and drives TDO like IDCODE.
- Undefined: opcode 3 decodes as BYPASS and no uc_shift register exists.

Test Plan:
- TRST pulse, then walk TLR->RTI->SEL_DR->CAP_DR->SH_DR x32 with TDI=0 -> TDO emits 32'h1234_5001 LSB first; ir_out=4'h1.
- Load IR=4'hF (BYPASS) via CAP_IR, SH_IR x4, UPD_IR; then SH_DR with TDI=1,0,1,1 -> TDO=0,1,0,1 (one-cycle delay). During CAP_IR-then-shift, TDO shows 1,0,0,0.
- Load IR=4'h2 (SAMPLE), pins_in=8'hA5, CAP_DR then SH_DR x8 -> TDO=1,0,1,0,0,1,0,1; pins_out still equals core_out=8'h3C.
- Load IR=4'h0 (EXTEST), shift 8'h96 into BSR, UPD_DR -> pins_out=8'h96 from the next cycle. Return to TLR -> ir_out=4'h1 and pins_out=core_out.
- Load IR=4'h7 (undefined) -> behaves as BYPASS. Assert TRST midway through an IR shift -> ir_out=4'h1 immediately, TDO_EN=0.
- With JTAG_USERCODE_EN: IR=4'h3, SH_DR x32 -> TDO emits 32'h0000_00A5. Without the macro, the same sequence returns the bypass pattern.

Source files
------------

// File: rtl/tap_data_path.sv
// JTAG data path: instruction register, BYPASS/IDCODE/boundary-scan data registers, TDO mux.
// Optional USERCODE register is enabled by defining JTAG_USERCODE_EN.
module tap_data_path #(
  parameter int          IR_WIDTH       = 4,
  parameter int          BSR_LEN        = 8,
  parameter logic [31:0] IDCODE_VALUE   = 32'h1234_5001,
  parameter logic [31:0] USERCODE_VALUE = 32'h0000_00A5
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic [3:0]          tap_state,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [BSR_LEN-1:0]  core_out,
  input  logic [BSR_LEN-1:0]  pins_in,
  output logic [BSR_LEN-1:0]  pins_out
);

  typedef enum logic [3:0] {
    ST_EX2_DR = 4'h0, ST_EX1_DR = 4'h1, ST_SH_DR  = 4'h2, ST_PAU_DR = 4'h3,
    ST_SEL_IR = 4'h4, ST_UPD_DR = 4'h5, ST_CAP_DR = 4'h6, ST_SEL_DR = 4'h7,
    ST_EX2_IR = 4'h8, ST_EX1_IR = 4'h9, ST_SH_IR  = 4'hA, ST_PAU_IR = 4'hB,
    ST_RTI    = 4'hC, ST_UPD_IR = 4'hD, ST_CAP_IR = 4'hE, ST_TLR    = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS, DR_IDCODE, DR_BSR, DR_USERCODE
  } dr_sel_t;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST   = '0;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(3);

  tap_state_t          state;
  dr_sel_t             dr_sel;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_upd;
  logic                bypass;
  logic [31:0]         id_shift;
  logic [BSR_LEN-1:0]  bsr_shift;
  logic [BSR_LEN-1:0]  bsr_upd;

  assign state  = tap_state_t'(tap_state);
  assign ir_out = ir_upd;

  // Undefined opcodes fall through to BYPASS so the chain length stays predictable.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_upd == OP_EXTEST || ir_upd == OP_SAMPLE)
      dr_sel = DR_BSR;
    else if (ir_upd == OP_IDCODE)
      dr_sel = DR_IDCODE;
`ifdef JTAG_USERCODE_EN
    else if (ir_upd == OP_USERCODE)
      dr_sel = DR_USERCODE;
`endif
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift <= '0;
      ir_upd   <= OP_IDCODE;
    end else begin
      case (state)
        ST_TLR:    ir_upd   <= OP_IDCODE;
        ST_CAP_IR: ir_shift <= IR_WIDTH'(1);
        ST_SH_IR:  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        ST_UPD_IR: ir_upd   <= ir_shift;
        default: ;
      endcase
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass <= 1'b0;
    end else if (dr_sel == DR_BYPASS) begin
      if (state == ST_CAP_DR)
        bypass <= 1'b0;
      else if (state == ST_SH_DR)
        bypass <= TDI;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      id_shift <= IDCODE_VALUE;
    end else if (dr_sel == DR_IDCODE) begin
      if (state == ST_CAP_DR)
        id_shift <= IDCODE_VALUE;
      else if (state == ST_SH_DR)
        id_shift <= {TDI, id_shift[31:1]};
    end
  end

  // The update stage keeps EXTEST pin values stable while a new pattern shifts through.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bsr_shift <= '0;
      bsr_upd   <= '0;
    end else if (dr_sel == DR_BSR) begin
      case (state)
        ST_CAP_DR: bsr_shift <= pins_in;
        ST_SH_DR:  bsr_shift <= {TDI, bsr_shift[BSR_LEN-1:1]};
        ST_UPD_DR: bsr_upd   <= bsr_shift;
        default: ;
      endcase
    end
  end

`ifdef JTAG_USERCODE_EN
  logic [31:0] uc_shift;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      uc_shift <= USERCODE_VALUE;
    end else if (dr_sel == DR_USERCODE) begin
      if (state == ST_CAP_DR)
        uc_shift <= USERCODE_VALUE;
      else if (state == ST_SH_DR)
        uc_shift <= {TDI, uc_shift[31:1]};
    end
  end
`endif

  always_comb begin
    TDO = 1'b0;
    if (!TRST) begin
      if (state == ST_SH_IR) begin
        TDO = ir_shift[0];
      end else if (state == ST_SH_DR) begin
        case (dr_sel)
          DR_IDCODE:   TDO = id_shift[0];
          DR_BSR:      TDO = bsr_shift[0];
`ifdef JTAG_USERCODE_EN
          DR_USERCODE: TDO = uc_shift[0];
`endif
          default:     TDO = bypass;
        endcase
      end
    end
  end

  assign TDO_EN   = !TRST && (state == ST_SH_IR || state == ST_SH_DR);
  assign pins_out = (ir_upd == OP_EXTEST) ? bsr_upd : core_out;

endmodule

// File: tb/tb_tap_data_path.sv
// Directed self-checking bench for tap_data_path; walks the TAP state codes by hand.
// Expects the USERCODE result according to whether JTAG_USERCODE_EN is defined.
module tb_tap_data_path;

  localparam logic [3:0] EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3;
  localparam logic [3:0] SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7;
  localparam logic [3:0] EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB;
  localparam logic [3:0] RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF;

  logic       TCK = 1'b0;
  logic       TRST;
  logic [3:0] tap_state;
  logic       TDI;
  logic       TDO;
  logic       TDO_EN;
  logic [3:0] ir_out;
  logic [7:0] core_out;
  logic [7:0] pins_in;
  logic [7:0] pins_out;

  int checks   = 0;
  int failures = 0;

  tap_data_path #(
    .IR_WIDTH(4), .BSR_LEN(8),
    .IDCODE_VALUE(32'h1234_5001), .USERCODE_VALUE(32'h0000_00A5)
  ) dut (
    .TCK(TCK), .TRST(TRST), .tap_state(tap_state), .TDI(TDI),
    .TDO(TDO), .TDO_EN(TDO_EN), .ir_out(ir_out),
    .core_out(core_out), .pins_in(pins_in), .pins_out(pins_out)
  );

  always #5 TCK = ~TCK;

  // Drive one TAP state for one TCK cycle; TDO/TDO_EN are sampled before the rising edge.
  task automatic clk_state(input logic [3:0] st, input logic tdi,
                           output logic tdo_s, output logic en_s);
    @(negedge TCK);
    tap_state = st;
    TDI       = tdi;
    #1;
    tdo_s = TDO;
    en_s  = TDO_EN;
    @(posedge TCK);
    #1;
  endtask

  task automatic go(input logic [3:0] st);
    logic d0, d1;
    clk_state(st, 1'b0, d0, d1);
  endtask

  task automatic load_ir(input logic [3:0] op, output logic [3:0] tdo_bits);
    logic en;
    go(SEL_DR); go(SEL_IR); go(CAP_IR);
    for (int i = 0; i < 4; i++) clk_state(SH_IR, op[i], tdo_bits[i], en);
    go(EX1_IR); go(UPD_IR); go(RTI);
  endtask

  // Leaves the DR path after the last SH_DR edge; caller finishes EX1/UPD.
  task automatic scan_dr(input int n, input logic [31:0] tdi_bits, output logic [31:0] tdo_bits);
    logic en;
    tdo_bits = '0;
    go(SEL_DR); go(CAP_DR);
    for (int i = 0; i < n; i++) clk_state(SH_DR, tdi_bits[i], tdo_bits[i], en);
  endtask

  task automatic test_reset();
    TRST = 1'b1; tap_state = TLR; TDI = 1'b0; core_out = 8'h3C; pins_in = 8'h00;
    #12;
    checks++;
    if (ir_out !== 4'h1) begin failures++; $display("[TB] FAIL reset_ir_out got=%h exp=1", ir_out); end
    checks++;
    if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_tdo got=%b/%b exp=0/0", TDO, TDO_EN);
    end
    checks++;
    if (pins_out !== 8'h3C) begin failures++; $display("[TB] FAIL reset_pins got=%h exp=3c", pins_out); end
    @(negedge TCK);
    TRST = 1'b0;
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    logic        en;
    go(TLR); go(RTI); go(SEL_DR); go(CAP_DR);
    got = '0;
    for (int i = 0; i < 32; i++) clk_state(SH_DR, 1'b0, got[i], en);
    checks++;
    if (got !== 32'h1234_5001) begin failures++; $display("[TB] FAIL idcode_shift got=%h exp=12345001", got); end
    checks++;
    if (en !== 1'b1) begin failures++; $display("[TB] FAIL idcode_tdo_en got=%b exp=1", en); end
    checks++;
    if (ir_out !== 4'h1) begin failures++; $display("[TB] FAIL idcode_ir_out got=%h exp=1", ir_out); end
    go(EX1_DR); go(UPD_DR); go(RTI);
  endtask

  task automatic test_bypass();
    logic [3:0]  cap;
    logic [31:0] got;
    load_ir(4'hF, cap);
    checks++;
    if (cap !== 4'b0001) begin failures++; $display("[TB] FAIL ir_capture got=%b exp=0001", cap); end
    checks++;
    if (ir_out !== 4'hF) begin failures++; $display("[TB] FAIL bypass_ir_out got=%h exp=f", ir_out); end
    scan_dr(4, 32'b1101, got);
    checks++;
    if (got[3:0] !== 4'b1010) begin failures++; $display("[TB] FAIL bypass_shift got=%b exp=1010", got[3:0]); end
    go(EX1_DR); go(UPD_DR); go(RTI);
  endtask

  task automatic test_sample();
    logic [3:0]  cap;
    logic [31:0] got;
    load_ir(4'h2, cap);
    pins_in = 8'hA5;
    scan_dr(8, 32'h5A, got);
    checks++;
    if (got[7:0] !== 8'hA5) begin failures++; $display("[TB] FAIL sample_capture got=%h exp=a5", got[7:0]); end
    go(EX1_DR); go(UPD_DR);
    checks++;
    if (pins_out !== 8'h3C) begin failures++; $display("[TB] FAIL sample_pins got=%h exp=3c", pins_out); end
    go(RTI);
  endtask

  task automatic test_extest();
    logic [3:0]  cap;
    logic [31:0] got;
    load_ir(4'h0, cap);
    checks++;
    if (pins_out !== 8'h5A) begin failures++; $display("[TB] FAIL extest_prev_upd got=%h exp=5a", pins_out); end
    scan_dr(8, 32'h96, got);
    checks++;
    if (got[7:0] !== 8'hA5) begin failures++; $display("[TB] FAIL extest_capture got=%h exp=a5", got[7:0]); end
    go(EX1_DR);
    checks++;
    if (pins_out !== 8'h5A) begin failures++; $display("[TB] FAIL extest_hold got=%h exp=5a", pins_out); end
    go(UPD_DR);
    checks++;
    if (pins_out !== 8'h96) begin failures++; $display("[TB] FAIL extest_update got=%h exp=96", pins_out); end
    go(TLR);
    checks++;
    if (ir_out !== 4'h1 || pins_out !== 8'h3C) begin
      failures++; $display("[TB] FAIL tlr_return got=%h/%h exp=1/3c", ir_out, pins_out);
    end
    go(RTI);
  endtask

  task automatic test_undefined();
    logic [3:0]  cap;
    logic [31:0] got;
    load_ir(4'h7, cap);
    checks++;
    if (ir_out !== 4'h7) begin failures++; $display("[TB] FAIL undef_ir_out got=%h exp=7", ir_out); end
    scan_dr(3, 32'b011, got);
    checks++;
    if (got[2:0] !== 3'b110) begin failures++; $display("[TB] FAIL undef_bypass got=%b exp=110", got[2:0]); end
    go(EX1_DR); go(UPD_DR); go(RTI);
  endtask

  task automatic test_pause_resume();
    logic [3:0] op = 4'hE;
    logic       tdo_s, en_s;
    go(SEL_DR); go(SEL_IR); go(CAP_IR);
    clk_state(SH_IR, op[0], tdo_s, en_s);
    clk_state(SH_IR, op[1], tdo_s, en_s);
    go(EX1_IR);
    clk_state(PAU_IR, 1'b1, tdo_s, en_s);
    clk_state(PAU_IR, 1'b1, tdo_s, en_s);
    checks++;
    if (tdo_s !== 1'b0 || en_s !== 1'b0) begin
      failures++; $display("[TB] FAIL pause_tdo got=%b/%b exp=0/0", tdo_s, en_s);
    end
    go(EX2_IR);
    clk_state(SH_IR, op[2], tdo_s, en_s);
    clk_state(SH_IR, op[3], tdo_s, en_s);
    go(EX1_IR);
    checks++;
    if (ir_out !== 4'h7) begin failures++; $display("[TB] FAIL pause_ir_hold got=%h exp=7", ir_out); end
    go(UPD_IR); go(RTI);
    checks++;
    if (ir_out !== 4'hE) begin failures++; $display("[TB] FAIL pause_resume got=%h exp=e", ir_out); end
  endtask

  task automatic test_trst_mid();
    logic tdo_s, en_s;
    go(SEL_DR); go(SEL_IR); go(CAP_IR);
    for (int i = 0; i < 4; i++) clk_state(SH_IR, 1'b1, tdo_s, en_s);
    @(negedge TCK);
    tap_state = SH_IR;
    TRST = 1'b1;
    #1;
    checks++;
    if (ir_out !== 4'h1) begin failures++; $display("[TB] FAIL trst_ir_out got=%h exp=1", ir_out); end
    checks++;
    if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin
      failures++; $display("[TB] FAIL trst_tdo got=%b/%b exp=0/0", TDO, TDO_EN);
    end
    @(posedge TCK);
    @(negedge TCK);
    TRST = 1'b0;
    TDI  = 1'b0;
    #1;
    checks++;
    if (TDO !== 1'b0 || TDO_EN !== 1'b1) begin
      failures++; $display("[TB] FAIL trst_discard got=%b/%b exp=0/1", TDO, TDO_EN);
    end
    go(TLR); go(RTI);
  endtask

  task automatic test_usercode();
    logic [3:0]  cap;
    logic [31:0] got;
    logic [31:0] exp;
`ifdef JTAG_USERCODE_EN
    exp = 32'h0000_00A5;
`else
    exp = 32'h0000_0000;
`endif
    load_ir(4'h3, cap);
    scan_dr(32, 32'h0, got);
    checks++;
    if (got !== exp) begin failures++; $display("[TB] FAIL usercode_shift got=%h exp=%h", got, exp); end
    go(EX1_DR); go(UPD_DR); go(RTI);
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_sample();
    test_extest();
    test_undefined();
    test_pause_resume();
    test_trst_mid();
    test_usercode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
